pipeline_arbiter: RTL and testbench

//   Round-robin arbiter sharing the 3-stage pipeline's input port among NUM_REQ requesters.

---
 rtl/pipeline_arbiter.sv | 131 +++++++++++++
 tb/tb_pipeline_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter feeding a shared 3-stage pipeline input. Each accepted word's
// requester ID rides a tag FIFO so results come back labelled, in order.
module pipeline_arbiter #(
  parameter int DATA_W       = 8,
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic                       pipe_dir_o,
  output logic [DATA_W-1:0]          pipe_data_o,
  input  logic                       pipe_ack_i,
  input  logic                       pipe_dor_i,
  input  logic [DATA_W-1:0]          pipe_dout_i,
  output logic                       pipe_ack_out_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [ID_W-1:0]            out_id_o,
  input  logic                       out_ready_i,
  output logic [CNT_W-1:0]           inflight_o,
  output logic                       err_underflow_o
);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef enum logic {IDLE, OFFER} state_e;

  state_e                            state_q;
  logic [ID_W-1:0]                   rr_q, grant_id_q;
  logic [DATA_W-1:0]                 pipe_data_q;
  logic                              pipe_dir_q;
  logic [NUM_REQ-1:0]                req_ack_q;
  logic [MAX_INFLIGHT-1:0][ID_W-1:0] tag_q;
  logic [PTR_W-1:0]                  wptr_q, rptr_q;
  logic [CNT_W-1:0]                  inflight_q;
  logic                              err_q;

  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_a;
  logic [ID_W-1:0]                   pick_id;
  logic                              found;
  int                                idx;
  logic                              can_grant, push, pop, fifo_empty, out_valid;

  assign req_data_a = req_data_i;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found   = 1'b1;
        pick_id = ID_W'(idx);
      end
    end
  end

  assign can_grant  = (state_q == IDLE) && found && (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign push       = (state_q == OFFER) && pipe_ack_i;
  assign fifo_empty = (inflight_q == '0);
  assign out_valid  = pipe_dor_i && !fifo_empty;
  assign pop        = out_valid && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      grant_id_q  <= '0;
      pipe_data_q <= '0;
      pipe_dir_q  <= 1'b0;
      req_ack_q   <= '0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        IDLE: if (can_grant) begin
          pipe_data_q <= req_data_a[pick_id];
          grant_id_q  <= pick_id;
          pipe_dir_q  <= 1'b1;
          state_q     <= OFFER;
        end
        OFFER: if (pipe_ack_i) begin
          req_ack_q[grant_id_q] <= 1'b1;
          rr_q       <= ID_W'((int'(grant_id_q) + 1) % NUM_REQ);
          pipe_dir_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag FIFO; the count doubles as the in-flight counter, so push+pop nets to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wptr_q] <= grant_id_q;
        wptr_q <= (wptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop)
        rptr_q <= (rptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      if (pipe_dor_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign req_ack_o       = req_ack_q;
  assign pipe_dir_o      = pipe_dir_q;
  assign pipe_data_o     = pipe_data_q;
  assign out_valid_o     = out_valid;
  assign out_data_o      = pipe_dout_i;
  assign out_id_o        = tag_q[rptr_q];
  assign pipe_ack_out_o  = pop;
  assign inflight_o      = inflight_q;
  assign err_underflow_o = err_q;
endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed bench: the bench plays the pipeline and the sink, checking grants, tags and limits.
module tb_pipeline_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ack_o;
  logic        pipe_dir_o;
  logic [7:0]  pipe_data_o;
  logic        pipe_ack_i, pipe_dor_i;
  logic [7:0]  pipe_dout_i;
  logic        pipe_ack_out_o, out_valid_o;
  logic [7:0]  out_data_o;
  logic [1:0]  out_id_o;
  logic        out_ready_i;
  logic [2:0]  inflight_o;
  logic        err_underflow_o;

  int checks = 0;
  int errors = 0;

  pipeline_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ack_o(req_ack_o), .pipe_dir_o(pipe_dir_o), .pipe_data_o(pipe_data_o),
    .pipe_ack_i(pipe_ack_i), .pipe_dor_i(pipe_dor_i), .pipe_dout_i(pipe_dout_i),
    .pipe_ack_out_o(pipe_ack_out_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_id_o(out_id_o), .out_ready_i(out_ready_i), .inflight_o(inflight_o),
    .err_underflow_o(err_underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #7;
    rst_ni = 1'b1;
    #1;
  endtask

  logic [7:0] dv [4];

  initial begin
    dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'h32; dv[3] = 8'h43;
    rst_ni = 1'b0; req_valid_i = '0; req_data_i = '0; pipe_ack_i = 0;
    pipe_dor_i = 0; pipe_dout_i = '0; out_ready_i = 0;
    #12;
    chk("rst_pipe_dir", pipe_dir_o, 0);
    chk("rst_req_ack", req_ack_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_err", err_underflow_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    rst_ni = 1'b1;
    tick();

    // 1: single requester
    req_valid_i = 4'b0001; req_data_i = 32'h0000_00A5;
    tick();
    chk("t1_pipe_dir", pipe_dir_o, 1);
    chk("t1_pipe_data", pipe_data_o, 8'hA5);
    chk("t1_no_ack_yet", req_ack_o, 0);
    pipe_ack_i = 1;
    tick();
    chk("t1_req_ack", req_ack_o, 4'b0001);
    chk("t1_inflight1", inflight_o, 1);
    chk("t1_dir_drop", pipe_dir_o, 0);
    pipe_ack_i = 0; req_valid_i = '0;
    tick();
    chk("t1_ack_pulse", req_ack_o, 0);
    pipe_dor_i = 1; pipe_dout_i = 8'hA5; out_ready_i = 1;
    #1;
    chk("t1_out_valid", out_valid_o, 1);
    chk("t1_out_data", out_data_o, 8'hA5);
    chk("t1_out_id", out_id_o, 0);
    chk("t1_pipe_ack_out", pipe_ack_out_o, 1);
    tick();
    pipe_dor_i = 0; out_ready_i = 0;
    chk("t1_inflight0", inflight_o, 0);

    // 2/4: all four requesting, sink stalled until full
    do_reset();
    req_valid_i = 4'b1111; req_data_i = {dv[3], dv[2], dv[1], dv[0]}; pipe_ack_i = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t2_dir_%0d", k), pipe_dir_o, 1);
      chk($sformatf("t2_data_%0d", k), pipe_data_o, dv[k]);
      tick();
      chk($sformatf("t2_ack_%0d", k), req_ack_o, 4'b0001 << k);
    end
    chk("t4_full", inflight_o, 4);
    tick();
    chk("t4_no_dir_a", pipe_dir_o, 0);
    tick();
    chk("t4_no_dir_b", pipe_dir_o, 0);
    pipe_ack_i = 0;
    pipe_dor_i = 1; pipe_dout_i = 8'h10; out_ready_i = 1;
    #1;
    chk("t4_pop_id", out_id_o, 0);
    tick();
    pipe_dor_i = 0; out_ready_i = 0;
    chk("t4_inflight3", inflight_o, 3);
    chk("t4_wait_cycle", pipe_dir_o, 0);
    tick();
    chk("t4_regrant", pipe_dir_o, 1);
    chk("t4_regrant_data", pipe_data_o, 8'h10);

    // 3: stalled OFFER holds data even if the requester's bus changes
    req_data_i[7:0] = 8'h99;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t3_dir_%0d", k), pipe_dir_o, 1);
      chk($sformatf("t3_data_%0d", k), pipe_data_o, 8'h10);
      chk($sformatf("t3_noack_%0d", k), req_ack_o, 0);
    end
    pipe_ack_i = 1;
    tick();
    chk("t3_ack", req_ack_o, 4'b0001);
    chk("t3_inflight4", inflight_o, 4);
    pipe_ack_i = 0; req_valid_i = '0;

    // drain: tags return in grant order 1,2,3,0
    pipe_dor_i = 1; out_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2_out_id_%0d", k), out_id_o, (k + 1) % 4);
      tick();
    end
    chk("t2_drained", inflight_o, 0);

    // 5: underflow
    #1;
    chk("t5_out_valid", out_valid_o, 0);
    chk("t5_pipe_ack_out", pipe_ack_out_o, 0);
    tick();
    pipe_dor_i = 0;
    chk("t5_err_set", err_underflow_o, 1);
    tick(); tick();
    chk("t5_err_sticky", err_underflow_o, 1);
    chk("t5_inflight", inflight_o, 0);

    // 6: async reset in OFFER with two in flight; rr was 1 after last grant of 0
    req_valid_i = 4'b0011; req_data_i = {dv[3], dv[2], dv[1], dv[0]}; pipe_ack_i = 1;
    tick();
    chk("t6_grant1", pipe_data_o, dv[1]);
    tick(); tick();
    chk("t6_grant0", pipe_data_o, dv[0]);
    tick();
    pipe_ack_i = 0;
    chk("t6_inflight2", inflight_o, 2);
    tick();
    chk("t6_offer", pipe_dir_o, 1);
    chk("t6_offer_data", pipe_data_o, dv[1]);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_dir", pipe_dir_o, 0);
    chk("t6_rst_ack", req_ack_o, 0);
    chk("t6_rst_inflight", inflight_o, 0);
    chk("t6_rst_err", err_underflow_o, 0);
    #3;
    rst_ni = 1'b1;
    tick();
    chk("t6_restart_dir", pipe_dir_o, 1);
    chk("t6_restart_req0", pipe_data_o, dv[0]);
    chk("t6_no_stale_ack", req_ack_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
